// File: rtl/random_range_sampler_pkg.sv
// Shared types and widths for the bounded random sampler.
// Imported by the sampler top and its mask helper.
package random_range_sampler_pkg;

   localparam int RAND_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      WAIT,
      DONE
   } state_e;

endpackage

// File: rtl/random_range_sampler_range_mask.sv
// Right-smear of a word: every bit below the top set bit is forced high,
// giving the smallest 2^k-1 that covers the input.
module range_mask
   import random_range_sampler_pkg::*;
(
   input  logic [RAND_W-1:0] x_i,
   output logic [RAND_W-1:0] mask_o
);

   logic [RAND_W-1:0] s1;
   logic [RAND_W-1:0] s2;
   logic [RAND_W-1:0] s4;

   assign s1     = x_i | (x_i >> 1);
   assign s2     = s1 | (s1 >> 2);
   assign s4     = s2 | (s2 >> 4);
   assign mask_o = s4 | (s4 >> 8);

endmodule

// File: rtl/random_range_sampler.sv
// Bounded random values in [0, limit) from a free-running random stream,
// via masked rejection sampling with a deterministic fallback.
module random_range_sampler
   import random_range_sampler_pkg::*;
#(
   parameter int STRIDE    = 16,
   parameter int MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RAND_W-1:0] random,
   input  logic              req,
   input  logic [RAND_W-1:0] limit,
   input  logic              ready,
   output logic              busy,
   output logic              valid,
   output logic [RAND_W-1:0] value,
   output logic              fallback
);

   localparam logic [CNT_W-1:0] TRY_LAST = CNT_W'(MAX_TRIES - 1);
   localparam logic [CNT_W-1:0] STR_LOAD = CNT_W'(STRIDE - 1);

   state_e            state_q, state_d;
   logic [RAND_W-1:0] lim_q, lim_d;
   logic [RAND_W-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]  tries_q, tries_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [RAND_W-1:0] value_q, value_d;
   logic              fb_q, fb_d;

   logic [RAND_W-1:0] smear;
   logic [RAND_W-1:0] mask_new;
   logic [RAND_W-1:0] cand;

   range_mask u_mask (
      .x_i    (limit - RAND_W'(1)),
      .mask_o (smear)
   );

   assign mask_new = (limit == '0) ? '1 : smear;
   assign cand     = random & mask_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lim_q   <= '0;
         mask_q  <= '0;
         tries_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         value_q <= '0;
         fb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lim_q   <= lim_d;
         mask_q  <= mask_d;
         tries_q <= tries_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         value_q <= value_d;
         fb_q    <= fb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lim_d   = lim_q;
      mask_d  = mask_q;
      tries_d = tries_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      value_d = value_q;
      fb_d    = fb_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               lim_d   = limit;
               mask_d  = mask_new;
               tries_d = '0;
               busy_d  = 1'b1;
               // one settling cycle so the first sample lands at T+2
               cnt_d   = CNT_W'(1);
               state_d = WAIT;
            end
         end
         SAMPLE: begin
            if (lim_q == '0 || cand < lim_q) begin
               value_d = cand;
               fb_d    = 1'b0;
               valid_d = 1'b1;
               state_d = DONE;
            end else if (tries_q == TRY_LAST) begin
               // mask < 2*lim, so this stays inside [0, lim)
               value_d = cand - lim_q;
               fb_d    = 1'b1;
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               tries_d = tries_q + CNT_W'(1);
               cnt_d   = STR_LOAD;
               state_d = (STRIDE == 1) ? SAMPLE : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = SAMPLE;
            end
         end
         DONE: begin
            if (ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               fb_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign value    = value_q;
   assign fallback = fb_q;

endmodule

// File: tb/tb_random_range_sampler.sv
// Bench for random_range_sampler: directed cases with literal expectations
// plus randomized traffic checked cycle by cycle against a reference model.
module tb_random_range_sampler;

   localparam int STRIDE    = 16;
   localparam int MAX_TRIES = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] random = '0;
   logic        req = 1'b0;
   logic [15:0] limit = '0;
   logic        ready = 1'b0;
   logic        busy;
   logic        valid;
   logic [15:0] value;
   logic        fallback;

   int checks = 0;
   int failures = 0;

   random_range_sampler #(
      .STRIDE    (STRIDE),
      .MAX_TRIES (MAX_TRIES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .random   (random),
      .req      (req),
      .limit    (limit),
      .ready    (ready),
      .busy     (busy),
      .valid    (valid),
      .value    (value),
      .fallback (fallback)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // smallest 2^k-1 that is >= limit-1; limit 0 means full range
   function automatic logic [15:0] mask_of(input logic [15:0] l);
      int m;
      if (l == 16'd0) return 16'hFFFF;
      m = 0;
      while (m < int'(l) - 1) m = m * 2 + 1;
      return 16'(m);
   endfunction

   // edges after the request edge at which the stream is sampled
   function automatic bit is_sample(input int age);
      return age >= 2 && ((age - 2) % STRIDE) == 0;
   endfunction

   function automatic logic [15:0] cand_of(input logic [15:0] r,
                                          input logic [15:0] l);
      return r & mask_of(l);
   endfunction

   logic        m_busy, m_valid, m_fb;
   logic [15:0] m_value, m_lim;
   int          m_age, m_tries;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_fb    <= 1'b0;
         m_value <= '0;
         m_lim   <= '0;
         m_age   <= 0;
         m_tries <= 0;
      end else if (!m_busy) begin
         if (req) begin
            m_busy  <= 1'b1;
            m_lim   <= limit;
            m_age   <= 0;
            m_tries <= 0;
         end
      end else if (m_valid) begin
         if (ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_fb    <= 1'b0;
         end
      end else begin
         m_age <= m_age + 1;
         if (is_sample(m_age + 1)) begin
            if (m_lim == 0 || cand_of(random, m_lim) < m_lim) begin
               m_value <= cand_of(random, m_lim);
               m_fb    <= 1'b0;
               m_valid <= 1'b1;
            end else if (m_tries == MAX_TRIES - 1) begin
               m_value <= cand_of(random, m_lim) - m_lim;
               m_fb    <= 1'b1;
               m_valid <= 1'b1;
            end else begin
               m_tries <= m_tries + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_valid", 32'(valid), 32'(m_valid));
      chk("m_value", 32'(value), 32'(m_value));
      chk("m_fallback", 32'(fallback), 32'(m_fb));
   end

   task automatic op(input logic [15:0] lim, input logic [15:0] r0,
                     input logic [15:0] r1, input int sw,
                     input logic [15:0] exp_v, input bit exp_fb,
                     input int exp_lat, input int hold);
      int  n;
      bit  seen;
      @(negedge clk);
      limit  = lim;
      random = r0;
      req    = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_after_req", 32'(busy), 32'd1);
      @(negedge clk);
      req = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk);
         n++;
         #1;
         if (valid) seen = 1'b1;
         else begin
            @(negedge clk);
            if (n >= sw) random = r1;
         end
      end
      if (!seen) chk("valid_timeout", 32'(n), 32'(exp_lat));
      else begin
         chk("latency", 32'(n), 32'(exp_lat));
         chk("value", 32'(value), 32'(exp_v));
         chk("fallback", 32'(fallback), 32'(exp_fb));
         chk("busy_done", 32'(busy), 32'd1);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         random = 16'($urandom);
         req    = 1'($urandom);
         limit  = 16'($urandom);
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(valid), 32'd1);
         chk("hold_value", 32'(value), 32'(exp_v));
      end
      @(negedge clk);
      req   = 1'b0;
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_valid", 32'(valid), 32'd0);
      chk("hs_busy", 32'(busy), 32'd0);
      chk("hs_value_kept", 32'(value), 32'(exp_v));
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_fallback", 32'(fallback), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      op(16'd10, 16'h0007, 16'h0007, 999, 16'd7, 1'b0, 2, 0);
      op(16'd10, 16'h000C, 16'h0003, 16, 16'd3, 1'b0, 18, 0);
      op(16'd10, 16'h000F, 16'h000F, 999, 16'd5, 1'b1, 114, 0);
      op(16'd0, 16'hBEEF, 16'hBEEF, 999, 16'hBEEF, 1'b0, 2, 20);

      @(negedge clk);
      limit  = 16'd10;
      random = 16'h000F;
      req    = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_value", 32'(value), 32'd0);
      chk("arst_fallback", 32'(fallback), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      op(16'd5, 16'h0004, 16'h0004, 999, 16'd4, 1'b0, 2, 0);
      op(16'd1, 16'hFFFF, 16'hFFFF, 999, 16'd0, 1'b0, 2, 0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         random = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
         req    = ($urandom % 4 == 0);
         ready  = ($urandom % 3 == 0);
         case ($urandom % 6)
            0: limit = 16'd0;
            1: limit = 16'd1;
            2: limit = 16'd10;
            3: limit = 16'h8001;
            4: limit = 16'($urandom % 32);
            default: limit = 16'($urandom);
         endcase
      end
      @(negedge clk);
      req   = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
